error_counter: RTL and testbench
================================

ERROR_COUNTER -- requirements
Module: error_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 10, count width in bits, two's complement.
REQ-002 SHALL have parameter LIMIT, default 384, saturation magnitude; legal only if 1 <= LIMIT <= 2^(WIDTH-1)-1.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port _pPGH  input  1  plus-pulse request, active-low.
REQ-006 SHALL have port _mPGH  input  1  minus-pulse request, active-low.
REQ-007 SHALL have port _ERENA  input  1  counter enable, active-low.
REQ-008 SHALL have port _ERCLR  input  1  synchronous clear to zero, active-low.
REQ-009 SHALL have port ec_count  output  WIDTH  registered signed count.
REQ-010 SHALL have port _ECLIM  output  1  limit flag, active-low; feeds the error-angle pulse-inhibit input.
REQ-011 SHALL have port _ECZERO  output  1  count-is-zero flag, active-low.
REQ-012 SHALL have port dac_val  output  WIDTH  DAC hold register.
REQ-013 SHALL have port dac_strb  output  1  one-cycle active-high strobe, dac_val updated.

Function
REQ-014 SHALL keep registered samples p_q, m_q of _pPGH/_mPGH; up event = p_q==1 and _pPGH==0 this edge; down event likewise for minus; a held-low input SHALL produce exactly one event.
REQ-015 SHALL implement FSM states DIS, RUN, SAT.
REQ-016 DIS: ec_count forced 0, events discarded; _ERENA==0 -> RUN next edge.
REQ-017 RUN: up event -> ec_count+1; down event -> ec_count-1; both in same cycle -> no change; result reaching +LIMIT or -LIMIT -> SAT.
REQ-018 SAT: event toward the limit ignored (no wrap, no change); event away from the limit applied -> RUN; simultaneous up/down -> no change, stay SAT.
REQ-019 From RUN or SAT, _ERENA==1 -> DIS and ec_count=0 on the same edge; pending events discarded.
REQ-020 _ERCLR==0 SHALL set ec_count=0 on that edge, overriding events, SAT -> RUN; in DIS no effect beyond count 0.
REQ-021 Event latency: ec_count reflects an event on the clock edge that detects the falling input; edge-history registers SHALL update every cycle regardless of state.
REQ-022 _ECLIM SHALL be 0 exactly while state==SAT (registered, same edge as state change).
REQ-023 _ECZERO SHALL be 0 exactly while ec_count==0 (registered, same edge).
REQ-024 dac_val SHALL load ec_count one cycle after any change of ec_count; dac_strb SHALL be 1 in that same cycle only; no strobe when count unchanged.
REQ-025 Arithmetic SHALL never wrap; magnitude SHALL never exceed LIMIT.

Reset
REQ-026 rst_n==0 at a rising edge SHALL force: state DIS, ec_count 0, dac_val 0, dac_strb 0, _ECLIM 1, _ECZERO 0, p_q 1, m_q 1.
REQ-027 Reset mid-operation SHALL take effect on that edge, overriding all other inputs; first event can be detected on the second edge after rst_n returns high and _ERENA==0.

Verification
REQ-028 Reset, _ERENA=0, 5 plus pulses (1 low cycle each, 1 high gap) -> ec_count=5, _ECZERO=1, dac_val=5 one cycle after last update, 5 dac_strb pulses.
REQ-029 _pPGH held low 20 cycles from count 0 -> ec_count=1, one dac_strb.
REQ-030 400 minus pulses from 0 -> ec_count=-384, _ECLIM=0 from the edge reaching -384; next plus pulse -> -383, _ECLIM=1.
REQ-031 Plus and minus falling on same edge at count 7 -> count stays 7, no dac_strb.
REQ-032 Count 12, _ERENA=1 -> ec_count=0, _ECZERO=0, state DIS; pulses while DIS -> count stays 0.
REQ-033 Count +384 (SAT), _ERCLR=0 one cycle -> ec_count=0, _ECLIM=1; rst_n=0 at count 50 -> all REQ-026 values next edge.

Source files
------------

// File: rtl/error_counter.sv
// error_counter: saturating signed up/down pulse counter with limit/zero flags and DAC hold register
module error_counter #(
  parameter int WIDTH = 10,
  parameter int LIMIT = 384
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             _pPGH,
  input  logic             _mPGH,
  input  logic             _ERENA,
  input  logic             _ERCLR,
  output logic [WIDTH-1:0] ec_count,
  output logic             _ECLIM,
  output logic             _ECZERO,
  output logic [WIDTH-1:0] dac_val,
  output logic             dac_strb
);
  localparam logic [WIDTH-1:0] POS = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] NEG = WIDTH'(-LIMIT);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  typedef enum logic [1:0] {DIS, RUN, SAT} state_t;
  state_t           state, state_d;
  logic [WIDTH-1:0] count_d;
  logic             p_q, m_q, up, dn, chg;
  assign up = p_q & ~_pPGH;
  assign dn = m_q & ~_mPGH;
  // Falling-edge history, sampled every cycle so a held-low request counts once
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q <= 1'b1;
      m_q <= 1'b1;
    end else begin
      p_q <= _pPGH;
      m_q <= _mPGH;
    end
  end
  // Next state and count: disable beats clear beats events; limit-ward events are dropped
  always_comb begin
    state_d = state;
    count_d = ec_count;
    case (state)
      DIS: begin
        count_d = '0;
        state_d = _ERENA ? DIS : RUN;
      end
      default: begin
        if (_ERENA) begin
          state_d = DIS;
          count_d = '0;
        end else if (!_ERCLR) begin
          state_d = RUN;
          count_d = '0;
        end else if (up && !dn && ec_count != POS) begin
          count_d = ec_count + ONE;
          state_d = (count_d == POS) ? SAT : RUN;
        end else if (dn && !up && ec_count != NEG) begin
          count_d = ec_count - ONE;
          state_d = (count_d == NEG) ? SAT : RUN;
        end
      end
    endcase
  end
  // State, count and flags all register on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= DIS;
      ec_count <= '0;
      _ECLIM   <= 1'b1;
      _ECZERO  <= 1'b0;
    end else begin
      state    <= state_d;
      ec_count <= count_d;
      _ECLIM   <= state_d != SAT;
      _ECZERO  <= count_d != '0;
    end
  end
  // DAC register follows the count one cycle behind, strobing only on real changes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chg      <= 1'b0;
      dac_strb <= 1'b0;
      dac_val  <= '0;
    end else begin
      chg      <= count_d != ec_count;
      dac_strb <= chg;
      if (chg) dac_val <= ec_count;
    end
  end
endmodule

// File: tb/tb_error_counter.sv
// tb_error_counter: table-driven plus directed corner-case checks for error_counter
module tb_error_counter;
  logic clk = 1'b0, rst_n = 1'b0, p = 1'b1, m = 1'b1, ena = 1'b1, clr = 1'b1;
  logic [9:0] ec_count, dac_val;
  logic eclim, ezero, strb;
  int errors = 0, checks = 0, strobes = 0;
  typedef struct {
    logic r, pp, mm, e, c;
    int   cnt;
    logic lim, zero, st;
    int   dac;
  } vec_t;
  vec_t vecs[21];
  always #5 clk = ~clk;
  error_counter dut (
    .clk(clk), .rst_n(rst_n), ._pPGH(p), ._mPGH(m), ._ERENA(ena), ._ERCLR(clr),
    .ec_count(ec_count), ._ECLIM(eclim), ._ECZERO(ezero), .dac_val(dac_val), .dac_strb(strb)
  );
  function automatic int cnt();
    return int'($signed(ec_count));
  endfunction
  function automatic int dac();
    return int'($signed(dac_val));
  endfunction
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (strb) strobes++;
  endtask
  task automatic do_reset();
    rst_n = 0; p = 1; m = 1; ena = 1; clr = 1;
    tick();
    rst_n = 1; ena = 0;
    tick();
  endtask
  task automatic plus_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      p = 0; tick();
      p = 1; tick();
    end
  endtask
  initial begin
    vecs[0]  = '{0,1,1,1,1,  0,1,0,0,  0};
    vecs[1]  = '{1,1,1,0,1,  0,1,0,0,  0};
    vecs[2]  = '{1,0,1,0,1,  1,1,1,0,  0};
    vecs[3]  = '{1,1,1,0,1,  1,1,1,1,  1};
    vecs[4]  = '{1,0,1,0,1,  2,1,1,0,  1};
    vecs[5]  = '{1,1,1,0,1,  2,1,1,1,  2};
    vecs[6]  = '{1,1,0,0,1,  1,1,1,0,  2};
    vecs[7]  = '{1,1,1,0,1,  1,1,1,1,  1};
    vecs[8]  = '{1,1,0,0,1,  0,1,0,0,  1};
    vecs[9]  = '{1,1,1,0,1,  0,1,0,1,  0};
    vecs[10] = '{1,1,0,0,1, -1,1,1,0,  0};
    vecs[11] = '{1,1,1,0,1, -1,1,1,1, -1};
    vecs[12] = '{1,0,0,0,1, -1,1,1,0, -1};
    vecs[13] = '{1,0,0,0,1, -1,1,1,0, -1};
    vecs[14] = '{1,1,1,0,1, -1,1,1,0, -1};
    vecs[15] = '{1,0,1,0,0,  0,1,0,0, -1};
    vecs[16] = '{1,1,1,0,1,  0,1,0,1,  0};
    vecs[17] = '{1,0,1,1,1,  0,1,0,0,  0};
    vecs[18] = '{1,1,1,1,1,  0,1,0,0,  0};
    vecs[19] = '{1,1,1,0,1,  0,1,0,0,  0};
    vecs[20] = '{1,0,1,0,1,  1,1,1,0,  0};
    for (int i = 0; i < 21; i++) begin
      rst_n = vecs[i].r; p = vecs[i].pp; m = vecs[i].mm; ena = vecs[i].e; clr = vecs[i].c;
      tick();
      check($sformatf("v%0d count", i), cnt(), vecs[i].cnt);
      check($sformatf("v%0d eclim", i), int'(eclim), int'(vecs[i].lim));
      check($sformatf("v%0d ezero", i), int'(ezero), int'(vecs[i].zero));
      check($sformatf("v%0d strb", i), int'(strb), int'(vecs[i].st));
      check($sformatf("v%0d dac", i), dac(), vecs[i].dac);
    end
    // five plus pulses
    do_reset();
    strobes = 0;
    for (int i = 0; i < 5; i++) begin
      p = 0; tick();
      if (i == 4) check("five dac lag", dac(), 4);
      p = 1; tick();
    end
    check("five count", cnt(), 5);
    check("five ezero", int'(ezero), 1);
    check("five dac", dac(), 5);
    check("five strobes", strobes, 5);
    // held-low plus input
    do_reset();
    strobes = 0;
    p = 0;
    repeat (20) tick();
    p = 1; tick();
    check("held count", cnt(), 1);
    check("held strobes", strobes, 1);
    // negative saturation
    do_reset();
    for (int i = 0; i < 400; i++) begin
      m = 0; tick();
      if (i == 383) begin
        check("neg reach count", cnt(), -384);
        check("neg reach eclim", int'(eclim), 0);
      end
      m = 1; tick();
    end
    check("neg sat count", cnt(), -384);
    check("neg sat eclim", int'(eclim), 0);
    p = 0; tick();
    check("neg leave count", cnt(), -383);
    check("neg leave eclim", int'(eclim), 1);
    p = 1; tick();
    // simultaneous plus and minus at 7
    do_reset();
    plus_pulses(7);
    strobes = 0;
    p = 0; m = 0; tick();
    check("both count", cnt(), 7);
    tick();
    p = 1; m = 1; tick();
    check("both count after", cnt(), 7);
    check("both strobes", strobes, 0);
    // disable at 12
    do_reset();
    plus_pulses(12);
    check("dis pre count", cnt(), 12);
    ena = 1; tick();
    check("dis count", cnt(), 0);
    check("dis ezero", int'(ezero), 0);
    plus_pulses(3);
    check("dis pulses count", cnt(), 0);
    ena = 0; p = 0; tick();
    check("dis reenable edge", cnt(), 0);
    p = 1; tick();
    p = 0; tick();
    check("dis first event", cnt(), 1);
    p = 1; tick();
    // positive saturation, clear, mid-run reset
    do_reset();
    for (int i = 0; i < 384; i++) begin
      p = 0; tick();
      if (i == 383) check("pos reach eclim", int'(eclim), 0);
      p = 1; tick();
    end
    p = 0; tick();
    check("pos sat count", cnt(), 384);
    check("pos sat eclim", int'(eclim), 0);
    p = 1; clr = 0; tick();
    check("clr count", cnt(), 0);
    check("clr eclim", int'(eclim), 1);
    check("clr ezero", int'(ezero), 0);
    clr = 1;
    plus_pulses(50);
    check("pre rst dac", dac(), 50);
    rst_n = 0; p = 0; tick();
    check("rst count", cnt(), 0);
    check("rst dac", dac(), 0);
    check("rst strb", int'(strb), 0);
    check("rst eclim", int'(eclim), 1);
    check("rst ezero", int'(ezero), 0);
    rst_n = 1; ena = 0; tick();
    tick();
    check("rst held p count", cnt(), 0);
    p = 1; tick();
    p = 0; tick();
    check("rst then event", cnt(), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
